// File: rtl/shift_issue_ctrl.sv
// Command FIFO and iteration controller feeding a 32-bit combinational barrel shifter.
// Optional zero-result flag output enabled by defining SHIFT_CTRL_ZFLAG_EN.
module shift_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int REPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  input  logic [4:0]      in_amt,
  input  logic            in_dir,
  input  logic [REPW-1:0] in_reps,
  output logic [31:0]     sh_a,
  output logic [4:0]      sh_amt,
  output logic            sh_dir,
  input  logic [31:0]     sh_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
`ifdef SHIFT_CTRL_ZFLAG_EN
  output logic            out_zero,
`endif
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [31:0]     fifo_data [DEPTH];
  logic [4:0]      fifo_amt  [DEPTH];
  logic            fifo_dir  [DEPTH];
  logic [REPW-1:0] fifo_reps [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  logic [1:0]      state;
  logic [31:0]     work_data;
  logic [4:0]      work_amt;
  logic            work_dir;
  logic [REPW-1:0] remaining;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  // A full FIFO refuses the push even when the controller pops on the same edge.
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;

  // NOTE: FIFO storage has no reset; count alone decides which entries are live,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= in_data;
      fifo_amt[wr_ptr]  <= in_amt;
      fifo_dir[wr_ptr]  <= in_dir;
      fifo_reps[wr_ptr] <= in_reps;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work_data <= '0;
      work_amt  <= '0;
      work_dir  <= 1'b0;
      remaining <= '0;
`ifdef SHIFT_CTRL_ZFLAG_EN
      out_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            work_data <= fifo_data[rd_ptr];
            work_amt  <= fifo_amt[rd_ptr];
            work_dir  <= fifo_dir[rd_ptr];
            remaining <= fifo_reps[rd_ptr];
            state     <= (fifo_reps[rd_ptr] == '0) ? DONE : SHIFT;
`ifdef SHIFT_CTRL_ZFLAG_EN
            out_zero  <= (fifo_data[rd_ptr] == '0);
`endif
          end
        end
        SHIFT: begin
          work_data <= sh_y;
          remaining <= remaining - 1'b1;
          if (remaining == REPW'(1)) state <= DONE;
`ifdef SHIFT_CTRL_ZFLAG_EN
          out_zero  <= (sh_y == '0);
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sh_a      = work_data;
  assign sh_amt    = work_amt;
  assign sh_dir    = work_dir;
  assign out_valid = (state == DONE);
  assign out_data  = work_data;
  assign busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl: a shifter model drives sh_y, and a scoreboard
// predicts every result from the command's data/amt/dir/reps at push time.
module tb_shift_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic [3:0]  in_reps;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic [31:0] sh_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef SHIFT_CTRL_ZFLAG_EN
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  shift_issue_ctrl #(.DEPTH(4), .REPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_reps   (in_reps),
    .sh_a      (sh_a),
    .sh_amt    (sh_amt),
    .sh_dir    (sh_dir),
    .sh_y      (sh_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFT_CTRL_ZFLAG_EN
    .out_zero  (out_zero),
`endif
    .busy      (busy)
  );

  // Stand-in for the downstream combinational barrel shifter.
  assign sh_y = sh_dir ? (sh_a << sh_amt) : (sh_a >> sh_amt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [31:0] d, input logic [4:0] amt,
                                               input logic dir, input logic [3:0] reps);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(reps); i++) r = dir ? (r << amt) : (r >> amt);
    return r;
  endfunction

  // Scoreboard: every cycle a result is offered it must equal the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
        else begin
          check("sb_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_result(in_data, in_amt, in_dir, in_reps));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] amt, input logic dir,
                       input logic [3:0] reps);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt;
    in_dir   = dir;
    in_reps  = reps;
  endtask

  task automatic push_one(input logic [31:0] d, input logic [4:0] amt, input logic dir,
                          input logic [3:0] reps);
    drive(d, amt, dir, reps);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic accepted;
    logic seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    in_reps   = '0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sh_a", sh_a, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);

    // Single left shift, reps=1: valid after T+2.
    push_one(32'h0000_0099, 5'd1, 1'b1, 4'd1);
    tick();
    check("t1_not_yet", out_valid, 1'b0);
    tick();
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 32'h0000_0132);
    accept();
    check("t1_drop", out_valid, 1'b0);

    // Iterated right shift: operand visible on sh_a for each pass.
    push_one(32'hF000_0000, 5'd4, 1'b0, 4'd3);
    tick();
    check("t2_sh_a0", sh_a, 32'hF000_0000);
    check("t2_sh_amt", sh_amt, 32'd4);
    check("t2_sh_dir", sh_dir, 1'b0);
    tick();
    check("t2_sh_a1", sh_a, 32'h0F00_0000);
    tick();
    check("t2_sh_a2", sh_a, 32'h00F0_0000);
    check("t2_not_yet", out_valid, 1'b0);
    tick();
    check("t2_valid", out_valid, 1'b1);
    check("t2_data", out_data, 32'h000F_0000);
    accept();

    // Pass-through, reps=0: valid after T+1.
    push_one(32'hDEAD_BEEF, 5'd7, 1'b1, 4'd0);
    tick();
    check("t3_valid", out_valid, 1'b1);
    check("t3_data", out_data, 32'hDEAD_BEEF);
    accept();

    // amt=0 with reps=2 still spends two shift cycles.
    push_one(32'h1234_5678, 5'd0, 1'b1, 4'd2);
    tick();
    tick();
    check("t4_not_yet", out_valid, 1'b0);
    tick();
    check("t4_valid", out_valid, 1'b1);
    check("t4_data", out_data, 32'h1234_5678);
    accept();

    // Overflow: bits shifted out are lost.
    push_one(32'h8000_0001, 5'd31, 1'b1, 4'd1);
    tick();
    tick();
    check("t5_data", out_data, 32'h8000_0000);
    accept();

    // Zero result and its flag.
    push_one(32'h0000_0001, 5'd1, 1'b0, 4'd1);
    tick();
    tick();
    check("z1_data", out_data, 32'h0);
`ifdef SHIFT_CTRL_ZFLAG_EN
    check("z1_flag", out_zero, 1'b1);
`endif
    accept();
    push_one(32'h0000_0002, 5'd1, 1'b0, 4'd1);
    tick();
    tick();
    check("z2_data", out_data, 32'h1);
`ifdef SHIFT_CTRL_ZFLAG_EN
    check("z2_flag", out_zero, 1'b0);
`endif
    accept();
    tick();

    // Backpressure: five accepted (one working, four queued), sixth held.
    for (int i = 0; i < 5; i++) begin
      drive(32'h11 * (i + 1), 5'(i), 1'(i), 4'd1);
      tick();
    end
    check("bp_full", in_ready, 1'b0);
    check("bp_busy", busy, 1'b1);
    drive(32'hCAFE_0006, 5'd2, 1'b1, 4'd2);
    tick();
    tick();
    check("bp_held", in_ready, 1'b0);
    check("bp_stable", out_data, 32'h11);
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      if (in_ready) accepted = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("bp_sixth_accepted", accepted, 1'b1);
    for (int k = 0; k < 100 && (busy || out_valid); k++) tick();
    check("bp_drained", busy, 1'b0);
    check("bp_sb_empty", exp_q.size(), 32'd0);
    out_ready = 1'b0;
    tick();

    // Reset during a long SHIFT with two commands queued.
    push_one(32'hA5A5_A5A5, 5'd1, 1'b1, 4'd15);
    push_one(32'h0000_0003, 5'd1, 1'b1, 4'd1);
    push_one(32'h0000_0004, 5'd1, 1'b0, 4'd1);
    tick();
    tick();
    check("rm_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_out_valid", out_valid, 1'b0);
    check("rm_out_data", out_data, 32'h0);
    check("rm_sh_a", sh_a, 32'h0);
    check("rm_sh_amt", sh_amt, 32'h0);
    check("rm_sh_dir", sh_dir, 1'b0);
    check("rm_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("rm_no_stale", seen_valid, 1'b0);
    check("rm_idle", busy, 1'b0);
    check("rm_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
